// File: rtl/placement_cost_eval_pkg.sv
// Shared definitions for the placement cost evaluator: default widths, FSM
// encoding and the saturating counter helper.
package placement_cost_eval_pkg;

  localparam int DW_DEF      = 32;
  localparam int EDGE_AW_DEF = 10;
  localparam int POS_AW_DEF  = 7;
  localparam int N_EDGE_DEF  = 88;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ERQ  = 3'd1,
    S_ECAP = 3'd2,
    S_ARQ  = 3'd3,
    S_ACAP = 3'd4,
    S_BCAP = 3'd5,
    S_ACC  = 3'd6,
    S_DONE = 3'd7
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/placement_cost_eval_manhattan_term.sv
// Per-edge Manhattan length, 1-hop term and skip classification for one
// pair of endpoint coordinates.
module manhattan_term #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] ax_i,
  input  logic [DW-1:0] ay_i,
  input  logic [DW-1:0] bx_i,
  input  logic [DW-1:0] by_i,
  output logic [DW-1:0] len_o,
  output logic [DW-1:0] hop_term_o,
  output logic          unplaced_o,
  output logic          collide_o
);

  logic [DW-1:0] diff_x, diff_y, dx, dy, hx, hy;

  assign diff_x = ax_i - bx_i;
  assign diff_y = ay_i - by_i;
  assign dx     = diff_x[DW-1] ? (~diff_x + 1'b1) : diff_x;
  assign dy     = diff_y[DW-1] ? (~diff_y + 1'b1) : diff_y;

  // ceil(d/2) without a divider
  assign hx = (dx >> 1) + {{(DW-1){1'b0}}, dx[0]};
  assign hy = (dy >> 1) + {{(DW-1){1'b0}}, dy[0]};

  assign len_o      = dx + dy;
  assign hop_term_o = hx + hy - 1'b1;
  assign unplaced_o = (&ax_i) | (&ay_i) | (&bx_i) | (&by_i);
  assign collide_o  = (len_o == '0);

endmodule

// File: rtl/placement_cost_eval.sv
// Start/done slave that walks the edge ROMs, fetches both endpoint positions
// and accumulates wirelength statistics, six cycles per edge.
module placement_cost_eval
  import placement_cost_eval_pkg::*;
#(
  parameter int N_EDGE  = N_EDGE_DEF,
  parameter int DW      = DW_DEF,
  parameter int EDGE_AW = EDGE_AW_DEF,
  parameter int POS_AW  = POS_AW_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               edge_rd,
  output logic [EDGE_AW-1:0] edge_addr,
  input  logic [DW-1:0]      edge_a,
  input  logic [DW-1:0]      edge_b,
  output logic               pos_rd,
  output logic [POS_AW-1:0]  pos_addr,
  input  logic [DW-1:0]      pos_x,
  input  logic [DW-1:0]      pos_y,
  output logic [DW-1:0]      cost_sum,
  output logic [DW-1:0]      cost_1hop,
  output logic [DW-1:0]      max_len,
  output logic [CNT_W-1:0]   n_unplaced,
  output logic [CNT_W-1:0]   n_collide
);

  localparam logic [EDGE_AW-1:0] LAST = (N_EDGE == 0) ? '0 : EDGE_AW'(N_EDGE - 1);

  state_t             state_q, state_d;
  logic [EDGE_AW-1:0] i_q, i_d;
  logic [POS_AW-1:0]  a_q, a_d, b_q, b_d;
  logic [DW-1:0]      ax_q, ax_d, ay_q, ay_d, bx_q, bx_d, by_q, by_d;
  logic [DW-1:0]      cost_sum_q, cost_sum_d, cost_1hop_q, cost_1hop_d;
  logic [DW-1:0]      max_len_q, max_len_d;
  logic [CNT_W-1:0]   n_unplaced_q, n_unplaced_d, n_collide_q, n_collide_d;

  logic [DW-1:0]      len, hop_term;
  logic               unplaced, collide;

  // Node ids fit the position RAM address; upper id bits are not used.
  logic unused_id_hi;
  assign unused_id_hi = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW]};

  manhattan_term #(.DW(DW)) u_term (
    .ax_i       (ax_q),
    .ay_i       (ay_q),
    .bx_i       (bx_q),
    .by_i       (by_q),
    .len_o      (len),
    .hop_term_o (hop_term),
    .unplaced_o (unplaced),
    .collide_o  (collide)
  );

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    a_d          = a_q;
    b_d          = b_q;
    ax_d         = ax_q;
    ay_d         = ay_q;
    bx_d         = bx_q;
    by_d         = by_q;
    cost_sum_d   = cost_sum_q;
    cost_1hop_d  = cost_1hop_q;
    max_len_d    = max_len_q;
    n_unplaced_d = n_unplaced_q;
    n_collide_d  = n_collide_q;
    case (state_q)
      S_IDLE: if (start) begin
        i_d          = '0;
        cost_sum_d   = '0;
        cost_1hop_d  = '0;
        max_len_d    = '0;
        n_unplaced_d = '0;
        n_collide_d  = '0;
        state_d      = (N_EDGE == 0) ? S_DONE : S_ERQ;
      end
      S_ERQ:  state_d = S_ECAP;
      S_ECAP: begin
        a_d     = edge_a[POS_AW-1:0];
        b_d     = edge_b[POS_AW-1:0];
        state_d = S_ARQ;
      end
      S_ARQ:  state_d = S_ACAP;
      S_ACAP: begin
        ax_d    = pos_x;
        ay_d    = pos_y;
        state_d = S_BCAP;
      end
      S_BCAP: begin
        bx_d    = pos_x;
        by_d    = pos_y;
        state_d = S_ACC;
      end
      S_ACC: begin
        if (unplaced) begin
          n_unplaced_d = sat_inc(n_unplaced_q);
        end else if (collide) begin
          n_collide_d = sat_inc(n_collide_q);
        end else begin
          cost_sum_d  = cost_sum_q + len - 1'b1;
          cost_1hop_d = cost_1hop_q + hop_term;
          if (len > max_len_q) max_len_d = len;
        end
        i_d     = i_q + 1'b1;
        state_d = (i_q == LAST) ? S_DONE : S_ERQ;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      a_q          <= '0;
      b_q          <= '0;
      ax_q         <= '0;
      ay_q         <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      cost_sum_q   <= '0;
      cost_1hop_q  <= '0;
      max_len_q    <= '0;
      n_unplaced_q <= '0;
      n_collide_q  <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      a_q          <= a_d;
      b_q          <= b_d;
      ax_q         <= ax_d;
      ay_q         <= ay_d;
      bx_q         <= bx_d;
      by_q         <= by_d;
      cost_sum_q   <= cost_sum_d;
      cost_1hop_q  <= cost_1hop_d;
      max_len_q    <= max_len_d;
      n_unplaced_q <= n_unplaced_d;
      n_collide_q  <= n_collide_d;
    end
  end

  // Memory strobes and addresses are pure decodes of the state register.
  assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done      = (state_q == S_DONE);
  assign edge_rd   = (state_q == S_ERQ);
  assign edge_addr = (state_q == S_ERQ) ? i_q : '0;
  assign pos_rd    = (state_q == S_ARQ) || (state_q == S_ACAP);
  assign pos_addr  = (state_q == S_ARQ)  ? a_q :
                     (state_q == S_ACAP) ? b_q : '0;

  assign cost_sum   = cost_sum_q;
  assign cost_1hop  = cost_1hop_q;
  assign max_len    = max_len_q;
  assign n_unplaced = n_unplaced_q;
  assign n_collide  = n_collide_q;

endmodule

// File: tb/tb_placement_cost_eval.sv
// Directed bench: a 3-edge evaluator and an empty-netlist evaluator driven
// from shared start/reset, with synchronous-read ROM/RAM models.
module tb_placement_cost_eval;

  localparam int DW = 32, EAW = 10, PAW = 7;

  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  always #5 clk = ~clk;

  // 3-edge instance
  logic           busy3, done3, erd3, prd3;
  logic [EAW-1:0] eaddr3;
  logic [PAW-1:0] paddr3;
  logic [DW-1:0]  ea_q, eb_q, px_q, py_q;
  logic [DW-1:0]  cs3, ch3, ml3;
  logic [15:0]    nu3, nc3;

  // empty-netlist instance
  logic           busy0, done0, erd0, prd0;
  logic [EAW-1:0] eaddr0;
  logic [PAW-1:0] paddr0;
  logic [DW-1:0]  cs0, ch0, ml0;
  logic [15:0]    nu0, nc0;
  logic [DW-1:0]  zero_w = '0;

  logic [DW-1:0] ea_mem [0:15];
  logic [DW-1:0] eb_mem [0:15];
  logic [DW-1:0] px_mem [0:127];
  logic [DW-1:0] py_mem [0:127];

  always @(posedge clk) begin
    if (erd3) begin
      ea_q <= ea_mem[eaddr3[3:0]];
      eb_q <= eb_mem[eaddr3[3:0]];
    end
    if (prd3) begin
      px_q <= px_mem[paddr3];
      py_q <= py_mem[paddr3];
    end
  end

  placement_cost_eval #(.N_EDGE(3), .DW(DW), .EDGE_AW(EAW), .POS_AW(PAW)) u3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy3), .done(done3),
    .edge_rd(erd3), .edge_addr(eaddr3), .edge_a(ea_q), .edge_b(eb_q),
    .pos_rd(prd3), .pos_addr(paddr3), .pos_x(px_q), .pos_y(py_q),
    .cost_sum(cs3), .cost_1hop(ch3), .max_len(ml3),
    .n_unplaced(nu3), .n_collide(nc3)
  );

  placement_cost_eval #(.N_EDGE(0), .DW(DW), .EDGE_AW(EAW), .POS_AW(PAW)) u0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy0), .done(done0),
    .edge_rd(erd0), .edge_addr(eaddr0), .edge_a(zero_w), .edge_b(zero_w),
    .pos_rd(prd0), .pos_addr(paddr0), .pos_x(zero_w), .pos_y(zero_w),
    .cost_sum(cs0), .cost_1hop(ch0), .max_len(ml0),
    .n_unplaced(nu0), .n_collide(nc0)
  );

  int nvec = 0, nerr = 0, rd0_cnt = 0;

  always @(negedge clk) if (erd0 || prd0) rd0_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_node(input int n, input int x, input int y);
    px_mem[n] = x;
    py_mem[n] = y;
  endtask

  // Start at cycle 0, optional start re-pulses and a reset cycle; runs a
  // fixed 40-cycle window and reports first done cycles and done count.
  task automatic run(input int p1, input int p2, input int rst_at,
                     output int dc3, output int nd3, output int dc0);
    dc3 = -1; nd3 = 0; dc0 = -1;
    @(negedge clk) start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 40; k++) begin
      if (done3) begin nd3++; if (dc3 < 0) dc3 = k; end
      if (done0 && dc0 < 0) dc0 = k;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk("rst_busy", {31'd0, busy3}, 32'd0);
        chk("rst_cost", cs3, 32'd0);
        chk("rst_max",  ml3, 32'd0);
      end
      start = (k == p1) || (k == p2);
      reset = (k == rst_at);
      @(negedge clk);
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  task automatic chk_res(input string tag, input int cs, input int ch, input int ml,
                         input int nu, input int nc);
    chk({tag, "_cost"}, cs3, cs);
    chk({tag, "_1hop"}, ch3, ch);
    chk({tag, "_max"},  ml3, ml);
    chk({tag, "_nu"},   {16'd0, nu3}, nu);
    chk({tag, "_nc"},   {16'd0, nc3}, nc);
  endtask

  int dc3, nd3, dc0;

  initial begin
    for (int i = 0; i < 16; i++) begin ea_mem[i] = '0; eb_mem[i] = '0; end
    for (int i = 0; i < 128; i++) begin px_mem[i] = '0; py_mem[i] = '0; end
    ea_mem[0] = 0; eb_mem[0] = 1;
    ea_mem[1] = 1; eb_mem[1] = 2;
    ea_mem[2] = 0; eb_mem[2] = 2;
    set_node(0, 0, 0); set_node(1, 3, 4); set_node(2, 3, 5);

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_state", {busy3, done3, erd3, prd3}, 4'b0);
    chk("rst_addr",  {eaddr3, paddr3}, 0);
    chk_res("rst", 0, 0, 0, 0, 0);

    // nominal run, plus empty netlist alongside
    run(0, 0, 0, dc3, nd3, dc0);
    chk("nom_done_cyc", dc3, 19);
    chk("nom_ndone", nd3, 1);
    chk_res("nom", 13, 7, 8, 0, 0);
    chk("e0_done_cyc", dc0, 1);
    chk("e0_cost", cs0, 0);
    chk("e0_1hop", ch0, 0);
    chk("e0_max", ml0, 0);
    chk("e0_cnt", {nu0, nc0}, 0);

    // start pulses while busy are ignored
    run(5, 9, 0, dc3, nd3, dc0);
    chk("ign_done_cyc", dc3, 19);
    chk("ign_ndone", nd3, 1);
    chk_res("ign", 13, 7, 8, 0, 0);

    // back-to-back rerun: accumulators cleared
    run(0, 0, 0, dc3, nd3, dc0);
    chk_res("b2b", 13, 7, 8, 0, 0);

    // node 1 unplaced
    set_node(1, -1, 4);
    run(0, 0, 0, dc3, nd3, dc0);
    chk_res("unpl", 7, 4, 8, 2, 0);

    // nodes 0,1 collide; node 2 unplaced
    set_node(0, 2, 2); set_node(1, 2, 2); set_node(2, -1, -1);
    run(0, 0, 0, dc3, nd3, dc0);
    chk_res("coll", 0, 0, 0, 2, 1);

    // reset mid-run then restart
    set_node(0, 0, 0); set_node(1, 3, 4); set_node(2, 3, 5);
    run(0, 0, 8, dc3, nd3, dc0);
    chk("rst_ndone", nd3, 0);
    run(0, 0, 0, dc3, nd3, dc0);
    chk("rerun_done_cyc", dc3, 19);
    chk_res("rerun", 13, 7, 8, 0, 0);

    chk("e0_no_reads", rd0_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
